// File: rtl/comp_pkg.sv
// Shared types and constants for the comparator stimulus/checker block.
package comp_pkg;

  localparam int         WIDTH_DEF     = 8;
  // Feedback taps: bits 7, 5, 4, 3.
  localparam logic [7:0] LFSR_TAPS     = 8'b1011_1000;
  localparam logic [7:0] LFSR_SEED_DEF = 8'h01;
  localparam logic [7:0] B_XOR_MASK    = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  // An all-zero seed would lock the LFSR, so substitute the default.
  function automatic logic [7:0] seed_fix(input logic [7:0] s);
    return (s == 8'h00) ? LFSR_SEED_DEF : s;
  endfunction

  function automatic logic [7:0] bit_rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

endpackage

// File: rtl/comp_lfsr8.sv
// 8-bit Fibonacci LFSR, shift left, feedback into bit 0.
module comp_lfsr8
  import comp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  output logic [7:0] state
);

  logic fb;
  assign fb = ^(state & LFSR_TAPS);

  // Load takes priority over advance; zero seed is replaced by the default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       state <= LFSR_SEED_DEF;
    else if (load)    state <= seed_fix(seed);
    else if (advance) state <= {state[6:0], fb};
  end

endmodule

// File: rtl/comp_stim_checker.sv
// Drives pseudo-random operand pairs to an external comparator and checks
// its L/E/G response against the ideal unsigned compare.
module comp_stim_checker
  import comp_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int RESP_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [7:0]       num_vec,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic             L,
  input  logic             E,
  input  logic             G,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [7:0]       vec_count,
  output logic [7:0]       first_err_idx
);

  // WAIT lasts RESP_LAT cycles: counter starts at RESP_LAT-1 and exits at 0.
  localparam logic [2:0] WAIT_INIT = (RESP_LAT > 0) ? 3'(RESP_LAT - 1) : 3'd0;

  state_t     state_q, state_d;
  logic [7:0] lfsr_state;
  logic [8:0] remaining;
  logic [2:0] wait_cnt;
  logic       start_acc;
  logic       last_vec;
  logic       load_vec;
  logic [7:0] op_src;
  logic [1:0] k_low;
  logic [7:0] b_next;
  logic [2:0] exp_leg;
  logic       mismatch;

  assign start_acc = (state_q == S_IDLE) && start;
  assign last_vec  = (remaining == 9'd1);
  // Operands are loaded on every entry into DRIVE so they are valid for
  // the whole DRIVE..CHECK window of that vector.
  assign load_vec  = start_acc || ((state_q == S_CHECK) && !last_vec);
  assign op_src    = start_acc ? seed_fix(8'(seed)) : lfsr_state;
  assign k_low     = start_acc ? 2'd0 : (vec_count[1:0] + 2'd1);
  assign b_next    = (k_low == 2'd0) ? op_src : (bit_rev8(op_src) ^ B_XOR_MASK);

  assign exp_leg   = {(A < B), (A == B), (A > B)};
  assign mismatch  = ({L, E, G} != exp_leg);

  assign busy = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done = (state_q == S_DONE);

  comp_lfsr8 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (start_acc),
    .seed    (8'(seed)),
    .advance (state_q == S_DRIVE),
    .state   (lfsr_state)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_DRIVE;
      S_DRIVE: state_d = (RESP_LAT > 0) ? S_WAIT : S_CHECK;
      S_WAIT:  if (wait_cnt == 3'd0) state_d = S_CHECK;
      S_CHECK: state_d = last_vec ? S_DONE : S_DRIVE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand registers, loaded on entry to DRIVE and held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A <= '0;
      B <= '0;
    end else if (load_vec) begin
      A <= WIDTH'(op_src);
      B <= WIDTH'(b_next);
    end
  end

  // Run bookkeeping: vector/latency counters, error tracking, pass flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining     <= '0;
      wait_cnt      <= '0;
      err_count     <= '0;
      vec_count     <= '0;
      first_err_idx <= '0;
      pass          <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          remaining     <= (num_vec == 8'd0) ? 9'd256 : {1'b0, num_vec};
          err_count     <= '0;
          vec_count     <= '0;
          first_err_idx <= '0;
          pass          <= 1'b0;
        end
        S_DRIVE: wait_cnt <= WAIT_INIT;
        S_WAIT:  if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
        S_CHECK: begin
          vec_count <= vec_count + 8'd1;
          remaining <= remaining - 9'd1;
          if (mismatch) begin
            // err_count is still zero only before the first mismatch.
            if (err_count == 8'd0) first_err_idx <= vec_count;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        S_DONE:  pass <= (err_count == 8'd0);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_stim_checker.sv
// Directed bench for comp_stim_checker with a behavioural comparator.
module tb_comp_stim_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] seed;
  logic [7:0] num_vec;
  logic [7:0] A, B;
  logic       L, E, G;
  logic       busy, done, pass;
  logic [7:0] err_count, vec_count, first_err_idx;

  // 0: ideal comparator, 1: all outputs tied low, 2: L and G swapped
  int mode;

  int checks = 0;
  int errors = 0;
  int cyc;

  // Hand-computed sequence for seed 8'h01 (LFSR: 01 02 04 08 11 23 47 8E).
  logic [7:0] exp_a [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
  logic [7:0] exp_b [8] = '{8'h01, 8'hE5, 8'h85, 8'hB5, 8'h11, 8'h61, 8'h47, 8'hD4};

  always #5 clk = ~clk;

  comp_stim_checker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .seed          (seed),
    .num_vec       (num_vec),
    .A             (A),
    .B             (B),
    .L             (L),
    .E             (E),
    .G             (G),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .vec_count     (vec_count),
    .first_err_idx (first_err_idx)
  );

  // Behavioural comparator with selectable faults.
  always_comb begin
    L = 1'b0; E = 1'b0; G = 1'b0;
    case (mode)
      0: begin L = (A < B); E = (A == B); G = (A > B); end
      2: begin L = (A > B); E = (A == B); G = (A < B); end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the start-sampling edge, i.e. at cycle 0.
  task automatic start_run(input logic [7:0] sd, input logic [7:0] n);
    seed = sd; num_vec = n; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int from, input int budget, output int c);
    c = from;
    while (!done && c < budget) begin
      step();
      c++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_A"},     32'(A), 32'd0);
    chk({tag, "_B"},     32'(B), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_pass"},  32'(pass), 32'd0);
    chk({tag, "_err"},   32'(err_count), 32'd0);
    chk({tag, "_vec"},   32'(vec_count), 32'd0);
    chk({tag, "_first"}, 32'(first_err_idx), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; seed = 8'h00; num_vec = 8'd0; mode = 0;
    #2;
    chk_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Ideal comparator, 16 vectors, and operand sequence for seed 01.
    mode = 0;
    start_run(8'h01, 8'd16);
    chk("r1_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("r1_A%0d", k), 32'(A), 32'(exp_a[k]));
      chk($sformatf("r1_B%0d", k), 32'(B), 32'(exp_b[k]));
      repeat (3) step();
    end
    wait_done(24, 200, cyc);
    chk("r1_done_cyc", 32'(cyc), 32'd48);
    chk("r1_busy_done", 32'(busy), 32'd0);
    chk("r1_err", 32'(err_count), 32'd0);
    chk("r1_vec", 32'(vec_count), 32'd16);
    step();
    chk("r1_pass", 32'(pass), 32'd1);
    chk("r1_done_pulse", 32'(done), 32'd0);

    // Seed 0 behaves like seed 01; mid-run and DONE-cycle starts ignored.
    start_run(8'h00, 8'd8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("r2_A%0d", k), 32'(A), 32'(exp_a[k]));
      chk($sformatf("r2_B%0d", k), 32'(B), 32'(exp_b[k]));
      if (k == 2) start = 1'b1;
      step();
      start = 1'b0;
      repeat (2) step();
    end
    wait_done(24, 200, cyc);
    chk("r2_done_cyc", 32'(cyc), 32'd24);
    chk("r2_vec", 32'(vec_count), 32'd8);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("r2_start_in_done", 32'(busy), 32'd0);
    chk("r2_pass", 32'(pass), 32'd1);

    // Comparator tied low: every vector mismatches.
    mode = 1;
    start_run(8'h01, 8'd10);
    wait_done(0, 200, cyc);
    chk("r3_done_cyc", 32'(cyc), 32'd30);
    step();
    chk("r3_err", 32'(err_count), 32'd10);
    chk("r3_first", 32'(first_err_idx), 32'd0);
    chk("r3_vec", 32'(vec_count), 32'd10);
    chk("r3_pass", 32'(pass), 32'd0);

    // L/G swapped: mismatches at k=1,2,3,5,7 (k=6 has A==B).
    mode = 2;
    start_run(8'h01, 8'd8);
    wait_done(0, 200, cyc);
    chk("r4_done_cyc", 32'(cyc), 32'd24);
    step();
    chk("r4_err", 32'(err_count), 32'd5);
    chk("r4_first", 32'(first_err_idx), 32'd1);
    chk("r4_pass", 32'(pass), 32'd0);

    // num_vec=0 runs 256 vectors; counters wrap/saturate.
    mode = 1;
    start_run(8'h01, 8'd0);
    wait_done(0, 2000, cyc);
    chk("r5_done_cyc", 32'(cyc), 32'd768);
    chk("r5_vec", 32'(vec_count), 32'd0);
    chk("r5_err", 32'(err_count), 32'd255);
    step();
    chk("r5_pass", 32'(pass), 32'd0);

    // Asynchronous reset during vector 5, then a clean rerun.
    mode = 2;
    start_run(8'h01, 8'd8);
    repeat (15) step();
    chk("r6_A5", 32'(A), 32'h23);
    chk("r6_err_pre", 32'(err_count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("r6_async");
    repeat (3) begin
      step();
      chk("r6_no_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    mode = 0;
    start_run(8'h01, 8'd8);
    chk("r7_A0", 32'(A), 32'h01);
    chk("r7_B0", 32'(B), 32'h01);
    chk("r7_vec0", 32'(vec_count), 32'd0);
    wait_done(0, 200, cyc);
    chk("r7_done_cyc", 32'(cyc), 32'd24);
    step();
    chk("r7_pass", 32'(pass), 32'd1);
    chk("r7_err", 32'(err_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
